// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit controller: register map,
// STATUS/CTRL bit positions, FSM state encoding and the busy-wait timeout.
package uart_pkg;

    // Register select values taken from addr[3:2]
    localparam logic [1:0] UART_REG_DATA   = 2'd0;
    localparam logic [1:0] UART_REG_STATUS = 2'd1;
    localparam logic [1:0] UART_REG_CTRL   = 2'd2;

    // STATUS bit positions
    localparam int STATUS_EMPTY_BIT  = 0;
    localparam int STATUS_FULL_BIT   = 1;
    localparam int STATUS_ACTIVE_BIT = 2;
    localparam int STATUS_OVF_BIT    = 3;
    localparam int STATUS_COUNT_LSB  = 8;

    // CTRL bit positions
    localparam int CTRL_ENABLE_BIT = 0;
    localparam int CTRL_FLUSH_BIT  = 1;
    localparam int CTRL_OVFCLR_BIT = 2;
    localparam int CTRL_IRQEN_BIT  = 3;

    typedef enum logic [1:0] {
        TX_IDLE      = 2'd0,
        TX_START     = 2'd1,
        TX_WAIT_BUSY = 2'd2,
        TX_WAIT_DONE = 2'd3
    } tx_state_e;

    // Cycles spent in WAIT_BUSY before giving up on the serialiser
    localparam int         BUSY_TIMEOUT  = 4;
    localparam logic [1:0] BUSY_TMR_LOAD = 2'(BUSY_TIMEOUT - 1);

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// CPU-side register bus of the UART transmit controller.
interface uart_tx_ctrl_if;
    logic        sel;
    logic        we;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output sel, output we, output addr, output wdata, input rdata);
    modport slave  (input sel, input we, input addr, input wdata, output rdata);
endinterface

// File: rtl/uart_tx_ctrl_sync_fifo.sv
// Synchronous FIFO with circular pointers, flush and occupancy count.
// A push into a full FIFO is accepted only when a pop happens on the same edge.
module sync_fifo #(
    parameter int  WIDTH = 8,
    parameter int  DEPTH = 16,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;

    // Next pointer/count; flush wins over any push or pop on the same edge
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and count registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write; contents need no reset since empty gates every read
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= wr_data;
    end
endmodule

// File: rtl/uart_tx_ctrl.sv
// Memory-mapped transmit controller feeding a uart_tx byte serialiser.
// CPU bytes are queued in a FIFO; the FSM launches one frame per byte
// through the start/busy handshake.
// Optional build macro: UART_TX_IRQ_EN adds the irq output and CTRL.irq_en.
//
// state        | meaning
// TX_IDLE      | waiting for enable and a queued byte
// TX_START     | utx_start high for this single cycle
// TX_WAIT_BUSY | waiting for the serialiser to report busy (bounded)
// TX_WAIT_DONE | frame in flight, waiting for busy to drop
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 16
) (
    input  logic           clk,
    input  logic           rst,
    uart_tx_ctrl_if.slave  bus,
    output logic           utx_start,
    output logic [7:0]     utx_data,
    input  logic           utx_busy
`ifdef UART_TX_IRQ_EN
    ,
    output logic           irq
`endif
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    tx_state_e        state_q;
    logic             utx_start_q;
    logic [7:0]       utx_data_q;
    logic [1:0]       tmr_q;
    logic             enable_q, enable_d;
    logic             overflow_q, overflow_d;
    logic             irq_en_bit;

    logic [1:0]       reg_idx;
    logic             wr_en, data_wr, ctrl_wr, flush, ovf_clr, ovf_set;
    logic             fifo_pop, fifo_full, fifo_empty;
    logic [7:0]       fifo_rd_data;
    logic [CNT_W-1:0] fifo_count;
    logic             unused_bus;

    assign reg_idx = bus.addr[3:2];
    assign wr_en   = bus.sel & bus.we;
    assign data_wr = wr_en & (reg_idx == UART_REG_DATA);
    assign ctrl_wr = wr_en & (reg_idx == UART_REG_CTRL);
    assign flush   = ctrl_wr & bus.wdata[CTRL_FLUSH_BIT];
    assign ovf_clr = ctrl_wr & bus.wdata[CTRL_OVFCLR_BIT];
    // A flush discards the head too, so the FSM does not pop on that edge
    assign fifo_pop = (state_q == TX_IDLE) & enable_q & ~fifo_empty & ~flush;
    assign ovf_set  = data_wr & fifo_full & ~fifo_pop & ~flush;
    assign unused_bus = ^{bus.addr[1:0], bus.wdata};

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (data_wr),
        .pop     (fifo_pop),
        .flush   (flush),
        .wr_data (bus.wdata[7:0]),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // CTRL/STATUS register next values; a new overflow beats a same-edge clear
    always_comb begin
        enable_d   = enable_q;
        overflow_d = overflow_q;
        if (ctrl_wr) enable_d = bus.wdata[CTRL_ENABLE_BIT];
        if (ovf_set)      overflow_d = 1'b1;
        else if (ovf_clr) overflow_d = 1'b0;
    end

    // Control register flops
    always_ff @(posedge clk) begin
        if (rst) begin
            enable_q   <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            enable_q   <= enable_d;
            overflow_q <= overflow_d;
        end
    end

    // Frame sequencer with registered start/data outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= TX_IDLE;
            utx_start_q <= 1'b0;
            utx_data_q  <= '0;
            tmr_q       <= '0;
        end else begin
            utx_start_q <= 1'b0;
            case (state_q)
                TX_IDLE: begin
                    if (fifo_pop) begin
                        utx_data_q  <= fifo_rd_data;
                        utx_start_q <= 1'b1;
                        state_q     <= TX_START;
                    end
                end
                TX_START: begin
                    tmr_q   <= BUSY_TMR_LOAD;
                    state_q <= TX_WAIT_BUSY;
                end
                TX_WAIT_BUSY: begin
                    if (utx_busy)           state_q <= TX_WAIT_DONE;
                    else if (tmr_q == 2'd0) state_q <= TX_IDLE;
                    else                    tmr_q   <= tmr_q - 2'd1;
                end
                TX_WAIT_DONE: begin
                    if (!utx_busy) state_q <= TX_IDLE;
                end
                default: state_q <= TX_IDLE;
            endcase
        end
    end

    assign utx_start = utx_start_q;
    assign utx_data  = utx_data_q;

`ifdef UART_TX_IRQ_EN
    logic irq_en_q, irq_en_d;
    logic irq_q;

    // irq_en follows CTRL writes
    always_comb begin
        irq_en_d = irq_en_q;
        if (ctrl_wr) irq_en_d = bus.wdata[CTRL_IRQEN_BIT];
    end

    // Level interrupt: queue drained and sequencer idle
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            irq_q    <= irq_en_q & fifo_empty & (state_q == TX_IDLE);
        end
    end

    assign irq        = irq_q;
    assign irq_en_bit = irq_en_q;
`else
    assign irq_en_bit = 1'b0;
`endif

    // Read mux, combinational and side-effect free
    always_comb begin
        bus.rdata = '0;
        if (bus.sel) begin
            case (reg_idx)
                UART_REG_STATUS: begin
                    bus.rdata[STATUS_EMPTY_BIT]          = fifo_empty;
                    bus.rdata[STATUS_FULL_BIT]           = fifo_full;
                    bus.rdata[STATUS_ACTIVE_BIT]         = (state_q != TX_IDLE);
                    bus.rdata[STATUS_OVF_BIT]            = overflow_q;
                    bus.rdata[STATUS_COUNT_LSB +: 8]     = 8'(fifo_count);
                end
                UART_REG_CTRL: begin
                    bus.rdata[CTRL_ENABLE_BIT] = enable_q;
                    bus.rdata[CTRL_IRQEN_BIT]  = irq_en_bit;
                end
                default: bus.rdata = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: behavioural serialiser model on the start/busy
// handshake, random bytes checked against an expected-frame queue.
module tb_uart_tx_ctrl;
    localparam int FRAME_CLKS = 40;
    localparam logic [3:0] A_DATA = 4'h0, A_STATUS = 4'h4, A_CTRL = 4'h8, A_RSV = 4'hC;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       utx_start;
    logic [7:0] utx_data;
    logic       utx_busy = 1'b0;
    logic       no_busy = 1'b0;
    int         busy_cnt = 0;
    int         start_while_busy = 0;
    logic [7:0] sent_q[$];
    logic [7:0] exp_q[$];
    int         checks = 0;
    int         errors = 0;
`ifdef UART_TX_IRQ_EN
    logic       irq;
`endif

    uart_tx_ctrl_if bus ();

    uart_tx_ctrl #(.FIFO_DEPTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .utx_start (utx_start),
        .utx_data  (utx_data),
        .utx_busy  (utx_busy)
`ifdef UART_TX_IRQ_EN
        ,
        .irq       (irq)
`endif
    );

    always #5 clk = ~clk;

    // Serialiser model: busy for a whole frame after each accepted start
    always @(posedge clk) begin
        if (rst) begin
            busy_cnt <= 0;
            utx_busy <= 1'b0;
        end else if (utx_start) begin
            if (utx_busy) start_while_busy <= start_while_busy + 1;
            sent_q.push_back(utx_data);
            if (!no_busy) begin
                utx_busy <= 1'b1;
                busy_cnt <= FRAME_CLKS - 1;
            end
        end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
        end else begin
            utx_busy <= 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        bus.sel = 1'b1; bus.we = 1'b1; bus.addr = a; bus.wdata = d;
        @(posedge clk); #1;
        bus.sel = 1'b0; bus.we = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        bus.sel = 1'b1; bus.we = 1'b0; bus.addr = a;
        #1;
        d = bus.rdata;
        bus.sel = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        logic [31:0] s;
        logic        done = 1'b0;
        for (int i = 0; i < 2000 && !done; i++) begin
            bus_read(A_STATUS, s);
            if (s[2] == 1'b0 && s[0] == 1'b1) done = 1'b1;
            else tick(1);
        end
        chk({tag, "_idle"}, {31'd0, done}, 32'd1);
    endtask

    task automatic chk_sent(input string tag);
        chk({tag, "_len"}, 32'(sent_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < sent_q.size(); i++)
            chk(tag, {24'd0, sent_q[i]}, {24'd0, exp_q[i]});
        sent_q.delete();
        exp_q.delete();
    endtask

    function automatic logic [31:0] status_of(int cnt, bit ovf, bit active);
        return (32'(cnt) << 8) | (32'(ovf) << 3) | (32'(active) << 2)
             | (32'(cnt == 16) << 1) | 32'(cnt == 0);
    endfunction

    initial begin
        logic [31:0] r;
        logic [7:0]  b;
        int          n, cnt;
        int          sizes[4];

        bus.sel = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;
        tick(3);
        rst = 1'b0;

        // Reset state
        chk("rst_start", {31'd0, utx_start}, 32'd0);
        chk("rst_data", {24'd0, utx_data}, 32'd0);
        bus_read(A_STATUS, r); chk("rst_status", r, 32'h1);
        bus_read(A_CTRL, r);   chk("rst_ctrl", r, 32'h1);
        bus_read(A_DATA, r);   chk("rd_data_zero", r, 32'h0);
        bus_read(A_RSV, r);    chk("rd_rsv_zero", r, 32'h0);
        bus.addr = A_CTRL; #1; chk("rd_nosel", bus.rdata, 32'h0);

        // Single byte: start pulse on the second edge, one cycle wide
        bus_write(A_DATA, 32'hFFFF_FF55); exp_q.push_back(8'h55);
        chk("t1_start_e0", {31'd0, utx_start}, 32'd0);
        tick(1);
        chk("t1_start_e1", {31'd0, utx_start}, 32'd1);
        chk("t1_data_e1", {24'd0, utx_data}, 32'h55);
        tick(1);
        chk("t1_start_e2", {31'd0, utx_start}, 32'd0);
        wait_idle("t1");
        bus_read(A_STATUS, r); chk("t1_status", r, 32'h1);
        chk_sent("t1_frames");

        // Fill while disabled with random byte counts, including full and overflow
        sizes[0] = 16; sizes[1] = 17;
        sizes[2] = int'($urandom_range(1, 15)); sizes[3] = int'($urandom_range(18, 20));
        for (int k = 0; k < 4; k++) begin
            n = sizes[k];
            bus_write(A_CTRL, 32'h0);
            cnt = 0;
            for (int i = 0; i < n; i++) begin
                b = 8'($urandom);
                bus_write(A_DATA, {24'd0, b});
                if (cnt < 16) begin exp_q.push_back(b); cnt++; end
            end
            bus_read(A_STATUS, r); chk("fill_status", r, status_of(cnt, n > 16, 1'b0));
            bus_write(A_CTRL, 32'h5);
            bus_read(A_STATUS, r); chk("fill_ovfclr", r, status_of(cnt, 1'b0, 1'b0));
            wait_idle("fill");
            chk_sent("fill_frames");
        end

        // Push into a full FIFO on the edge the sequencer pops: accepted
        bus_write(A_CTRL, 32'h0);
        for (int i = 0; i < 16; i++) begin
            b = 8'($urandom); bus_write(A_DATA, {24'd0, b}); exp_q.push_back(b);
        end
        bus_write(A_CTRL, 32'h1);
        b = 8'($urandom); bus_write(A_DATA, {24'd0, b}); exp_q.push_back(b);
        bus_read(A_STATUS, r); chk("pushpop_status", r, status_of(16, 1'b0, 1'b1));
        wait_idle("pushpop");
        chk_sent("pushpop_frames");

        // Serialiser never answers: give up after the busy timeout
        no_busy = 1'b1;
        bus_write(A_DATA, 32'hA7); exp_q.push_back(8'hA7);
        tick(5);
        bus_read(A_STATUS, r); chk("tmo_active", r, 32'h5);
        tick(1);
        bus_read(A_STATUS, r); chk("tmo_idle", r, 32'h1);
        no_busy = 1'b0;
        chk_sent("tmo_frames");

        // Enable cleared mid-frame: frame finishes, queue holds, pushes still land
        bus_write(A_DATA, 32'h41); bus_write(A_DATA, 32'h42); bus_write(A_DATA, 32'h43);
        bus_write(A_CTRL, 32'h0);
        tick(60);
        bus_read(A_STATUS, r); chk("dis_status", r, status_of(2, 1'b0, 1'b0));
        bus_write(A_DATA, 32'h44);
        bus_read(A_STATUS, r); chk("dis_push", r, status_of(3, 1'b0, 1'b0));
        exp_q.push_back(8'h41); chk_sent("dis_frames");
        bus_write(A_CTRL, 32'h1);
        wait_idle("dis");
        exp_q.push_back(8'h42); exp_q.push_back(8'h43); exp_q.push_back(8'h44);
        chk_sent("dis_rest");

        // Flush with five queued behind an active frame
        for (int i = 0; i < 6; i++) bus_write(A_DATA, 32'(8'h60 + i));
        bus_read(A_STATUS, r); chk("fl_before", r, status_of(5, 1'b0, 1'b1));
        bus_write(A_CTRL, 32'h3);
        bus_read(A_STATUS, r); chk("fl_after", r, status_of(0, 1'b0, 1'b1));
        wait_idle("fl");
        exp_q.push_back(8'h60);
        chk_sent("fl_frames");

`ifdef UART_TX_IRQ_EN
        // Interrupt tracks drained-and-idle
        bus_write(A_CTRL, 32'h9);
        tick(1);
        chk("irq_idle", {31'd0, irq}, 32'd1);
        bus_write(A_DATA, 32'h3C); exp_q.push_back(8'h3C);
        tick(1);
        chk("irq_queued", {31'd0, irq}, 32'd0);
        wait_idle("irq");
        chk("irq_edge", {31'd0, irq}, 32'd0);
        tick(1);
        chk("irq_done", {31'd0, irq}, 32'd1);
        bus_write(A_CTRL, 32'h1);
        tick(1);
        chk("irq_off", {31'd0, irq}, 32'd0);
        chk_sent("irq_frames");
`endif

        // Reset in the middle of a frame
        bus_write(A_CTRL, 32'h9);
        bus_write(A_DATA, 32'h11); bus_write(A_DATA, 32'h22);
        tick(10);
        rst = 1'b1;
        tick(1);
        chk("mrst_start", {31'd0, utx_start}, 32'd0);
        chk("mrst_data", {24'd0, utx_data}, 32'd0);
        bus_read(A_STATUS, r); chk("mrst_status", r, 32'h1);
        bus_read(A_CTRL, r);   chk("mrst_ctrl", r, 32'h1);
        rst = 1'b0;
        tick(50);
        exp_q.push_back(8'h11);
        chk_sent("mrst_frames");

        chk("start_while_busy", 32'(start_while_busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
